// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared constants for the SD command sequencer: FIFO-controller register map,
// status bits, response type codes and the sequencer state encoding.
package sd_cmd_sequencer_pkg;

  localparam logic [2:0] ADR_TX_CMD = 3'd0;
  localparam logic [2:0] ADR_RX_CMD = 3'd1;
  localparam logic [2:0] ADR_STATUS = 3'd4;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_RX_EMPTY = 1;

  localparam logic [1:0] RSP_NONE  = 2'd0;
  localparam logic [1:0] RSP_SHORT = 2'd1;
  localparam logic [1:0] RSP_LONG  = 2'd2;

  localparam logic [4:0] LEN_SHORT = 5'd6;
  localparam logic [4:0] LEN_LONG  = 5'd17;

  localparam logic [1:0] FRAME_PREFIX = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StTxPoll,
    StTxWr,
    StRspChk,
    StRxPoll,
    StRxRd,
    StFinish
  } seq_state_e;

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Wishbone link between the command sequencer (master) and the SD FIFO
// controller slave port.
interface sd_cmd_sequencer_if;
  logic [2:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i;
  logic       m_we_o;
  logic [3:0] m_sel_o;
  logic       m_cyc_o;
  logic       m_stb_o;
  logic       m_ack_i;

  modport master (
    output m_adr_o, m_dat_o, m_we_o, m_sel_o, m_cyc_o, m_stb_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_we_o, m_sel_o, m_cyc_o, m_stb_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/sd_crc7_byte.sv
// One byte step of the SD CRC7 (x^7 + x^3 + 1), data taken MSB first.
module sd_crc7_byte (
  input  logic [6:0] crc_in,
  input  logic [7:0] data_in,
  output logic [6:0] crc_out
);

  logic fb;

  always_comb begin
    crc_out = crc_in;
    fb      = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb      = crc_out[6] ^ data_in[i];
      crc_out = {crc_out[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Wishbone master that sends one SD command frame through the FIFO controller
// and collects the response bytes with an inter-byte timeout.
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int unsigned   TW      = 16,
  parameter logic [TW-1:0] TIMEOUT = TW'(4095)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic [5:0]         cmd_idx_i,
  input  logic [31:0]        cmd_arg_i,
  input  logic [1:0]         rsp_type_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_timeout_o,
  output logic               err_index_o,
  output logic [127:0]       resp_o,
  sd_cmd_sequencer_if.master wb
);

  seq_state_e    state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic [1:0]    type_q, type_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    crc_q, crc_d, crc_next;
  logic [127:0]  resp_q, resp_d;
  logic          err_to_q, err_to_d;
  logic          err_idx_q, err_idx_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [2:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    frame_byte;
  logic          ack;

  assign ack = cyc_q & wb.m_ack_i;

  always_comb begin
    case (cnt_q)
      5'd0:    frame_byte = {FRAME_PREFIX, idx_q};
      5'd1:    frame_byte = arg_q[31:24];
      5'd2:    frame_byte = arg_q[23:16];
      5'd3:    frame_byte = arg_q[15:8];
      5'd4:    frame_byte = arg_q[7:0];
      default: frame_byte = {crc_q, 1'b1};
    endcase
  end

  sd_crc7_byte u_crc7 (
    .crc_in  (crc_q),
    .data_in (frame_byte),
    .crc_out (crc_next)
  );

  // Every bus state launches an access when cyc is low; the cycle after ack is the gap.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    type_d    = type_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    timer_d   = timer_q;
    crc_d     = crc_q;
    resp_d    = resp_q;
    err_to_d  = err_to_q;
    err_idx_d = err_idx_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d     = cmd_idx_i;
          arg_d     = cmd_arg_i;
          type_d    = rsp_type_i;
          err_to_d  = 1'b0;
          err_idx_d = 1'b0;
          resp_d    = '0;
          cnt_d     = '0;
          crc_d     = '0;
          state_d   = StTxPoll;
        end
      end
      StTxPoll: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = ADR_STATUS;
        end else if (ack) begin
          cyc_d = 1'b0;
          if (!wb.m_dat_i[ST_TX_FULL]) state_d = StTxWr;
        end
      end
      StTxWr: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = ADR_TX_CMD;
          dat_d = frame_byte;
        end else if (ack) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (cnt_q == 5'd5) begin
            state_d = StRspChk;
          end else begin
            crc_d   = crc_next;
            cnt_d   = cnt_q + 5'd1;
            state_d = StTxPoll;
          end
        end
      end
      StRspChk: begin
        if (type_q == RSP_SHORT || type_q == RSP_LONG) begin
          len_d   = (type_q == RSP_SHORT) ? LEN_SHORT : LEN_LONG;
          timer_d = TIMEOUT;
          cnt_d   = '0;
          state_d = StRxPoll;
        end else begin
          state_d = StFinish;
        end
      end
      StRxPoll: begin
        timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        if (!cyc_q) begin
          if (timer_q == '0) begin
            err_to_d = 1'b1;
            state_d  = StFinish;
          end else begin
            cyc_d = 1'b1;
            we_d  = 1'b0;
            adr_d = ADR_STATUS;
          end
        end else if (ack) begin
          cyc_d = 1'b0;
          // A byte found on the final poll still wins over the timeout.
          if (!wb.m_dat_i[ST_RX_EMPTY]) state_d = StRxRd;
        end
      end
      StRxRd: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = ADR_RX_CMD;
        end else if (ack) begin
          cyc_d   = 1'b0;
          resp_d  = {resp_q[119:0], wb.m_dat_i};
          timer_d = TIMEOUT;
          if (cnt_q == '0 && type_q == RSP_SHORT && wb.m_dat_i[5:0] != idx_q) begin
            err_idx_d = 1'b1;
          end
          if (cnt_q == len_q - 5'd1) begin
            state_d = StFinish;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = StRxPoll;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      arg_q     <= '0;
      type_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      timer_q   <= '0;
      crc_q     <= '0;
      resp_q    <= '0;
      err_to_q  <= 1'b0;
      err_idx_q <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      arg_q     <= arg_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      timer_q   <= timer_d;
      crc_q     <= crc_d;
      resp_q    <= resp_d;
      err_to_q  <= err_to_d;
      err_idx_q <= err_idx_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
    end
  end

  assign busy_o        = (state_q != StIdle) && (state_q != StFinish);
  assign done_o        = (state_q == StFinish);
  assign err_timeout_o = err_to_q;
  assign err_index_o   = err_idx_q;
  assign resp_o        = resp_q;

  assign wb.m_adr_o = adr_q;
  assign wb.m_dat_o = dat_q;
  assign wb.m_we_o  = we_q;
  assign wb.m_sel_o = 4'b0001;
  assign wb.m_cyc_o = cyc_q;
  assign wb.m_stb_o = cyc_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: behavioural FIFO-controller slave plus a
// frame/response reference model built from the command and response rules.
module tb_sd_cmd_sequencer;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i;
  logic         start_i;
  logic [5:0]   cmd_idx_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   rsp_type_i;
  logic         busy_o, done_o, err_timeout_o, err_index_o;
  logic [127:0] resp_o;

  always #5 wb_clk_i = ~wb_clk_i;

  sd_cmd_sequencer_if bus ();

  sd_cmd_sequencer #(
    .TW      (16),
    .TIMEOUT (16'd20)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .start_i       (start_i),
    .cmd_idx_i     (cmd_idx_i),
    .cmd_arg_i     (cmd_arg_i),
    .rsp_type_i    (rsp_type_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_timeout_o (err_timeout_o),
    .err_index_o   (err_index_o),
    .resp_o        (resp_o),
    .wb            (bus.master)
  );

  int checks = 0;
  int failures = 0;

  // Owned by the stimulus block.
  logic [7:0] rx_mem [0:1023];
  int         rx_wr = 0;
  longint     tx_full_until = 0;
  logic [7:0] rb [0:16];
  logic [47:0] last_frame;

  // Owned by the slave / monitors.
  longint      cyc_cnt = 0;
  longint      last_wr_cyc = 0;
  int          rx_rd = 0;
  int          rd1_cnt = 0;
  int          st_cnt = 0;
  int          prot_err = 0;
  int          done_cnt = 0;
  logic [7:0]  tx_log [$];
  logic        s_ack;
  logic [7:0]  s_dat;
  int unsigned wait_cnt;
  logic        in_acc, gap_chk, we_s;
  logic [2:0]  adr_s;
  logic [7:0]  dat_s;

  assign bus.m_ack_i = s_ack;
  assign bus.m_dat_i = s_dat;

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;
  always @(posedge wb_clk_i) if (done_o) done_cnt <= done_cnt + 1;

  // FIFO-controller slave: random ack latency, protocol watchdog.
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s_ack    <= 1'b0;
      s_dat    <= 8'h00;
      wait_cnt <= 0;
      in_acc   <= 1'b0;
      gap_chk  <= 1'b0;
    end else begin
      gap_chk <= 1'b0;
      if (gap_chk && bus.m_cyc_o) prot_err <= prot_err + 1;
      if (s_ack) begin
        s_ack   <= 1'b0;
        in_acc  <= 1'b0;
        gap_chk <= 1'b1;
      end else if (bus.m_cyc_o) begin
        if (!bus.m_stb_o || bus.m_sel_o != 4'b0001) prot_err <= prot_err + 1;
        if (!in_acc) begin
          in_acc <= 1'b1;
          adr_s  <= bus.m_adr_o;
          we_s   <= bus.m_we_o;
          dat_s  <= bus.m_dat_o;
        end else if (bus.m_adr_o != adr_s || bus.m_we_o != we_s ||
                     (we_s && bus.m_dat_o != dat_s)) begin
          prot_err <= prot_err + 1;
        end
        if (wait_cnt != 0) begin
          wait_cnt <= wait_cnt - 1;
        end else begin
          s_ack    <= 1'b1;
          wait_cnt <= $urandom_range(0, 2);
          case (bus.m_adr_o)
            3'd4: begin
              s_dat  <= {6'b0, (rx_rd >= rx_wr), (cyc_cnt < tx_full_until)};
              st_cnt <= st_cnt + 1;
              if (bus.m_we_o) prot_err <= prot_err + 1;
            end
            3'd0: begin
              if (bus.m_we_o) begin
                tx_log.push_back(bus.m_dat_o);
                last_wr_cyc <= cyc_cnt;
              end else begin
                prot_err <= prot_err + 1;
              end
            end
            3'd1: begin
              rd1_cnt <= rd1_cnt + 1;
              if (!bus.m_we_o && rx_rd < rx_wr) begin
                s_dat <= rx_mem[rx_rd];
                rx_rd <= rx_rd + 1;
              end else begin
                s_dat    <= 8'hEE;
                prot_err <= prot_err + 1;
              end
            end
            default: prot_err <= prot_err + 1;
          endcase
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Frame = prefix/index/argument followed by the CRC7 remainder of M(x)*x^7 / G(x).
  function automatic logic [47:0] frame_model(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    logic [46:0] rem;
    msg = {2'b01, idx, arg};
    rem = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (rem[i]) rem[i-:8] = rem[i-:8] ^ 8'h89;
    end
    return {msg, rem[6:0], 1'b1};
  endfunction

  task automatic run_txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input bit load_rsp, input bit poke);
    int           n, tx0, rd0, d0;
    logic [47:0]  exp_frame, obs_frame;
    logic [127:0] exp_resp;
    logic         exp_ei, exp_to;
    bit           got;
    longint       dt;
    n         = (rt == 2'd1) ? 6 : (rt == 2'd2) ? 17 : 0;
    exp_frame = frame_model(idx, arg);
    exp_resp  = '0;
    exp_ei    = 1'b0;
    exp_to    = (n != 0) && !load_rsp;
    if (load_rsp) begin
      for (int k = 0; k < n; k++) begin
        rx_mem[rx_wr] = rb[k];
        rx_wr++;
      end
      if (n == 6) begin
        for (int k = 0; k < 6; k++) exp_resp[(5-k)*8 +: 8] = rb[k];
        exp_ei = (rb[0][5:0] != idx);
      end else if (n == 17) begin
        for (int k = 1; k < 17; k++) exp_resp[(16-k)*8 +: 8] = rb[k];
      end
    end
    tx0 = tx_log.size();
    rd0 = rd1_cnt;
    d0  = done_cnt;

    @(negedge wb_clk_i);
    cmd_idx_i  = idx;
    cmd_arg_i  = arg;
    rsp_type_i = rt;
    start_i    = 1'b1;
    @(negedge wb_clk_i);
    start_i   = 1'b0;
    cmd_idx_i = ~idx;
    cmd_arg_i = ~arg;
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (done_o) begin
        got = 1;
      end else begin
        if (poke && c == 8) begin
          start_i = 1'b1;
        end else begin
          start_i = 1'b0;
        end
        @(negedge wb_clk_i);
      end
    end
    start_i = 1'b0;
    check({tag, "_done_seen"}, got, 1'b1);
    dt = cyc_cnt - last_wr_cyc;
    check({tag, "_resp"}, resp_o, exp_resp);
    check({tag, "_err_index"}, err_index_o, exp_ei);
    check({tag, "_err_timeout"}, err_timeout_o, exp_to);
    @(negedge wb_clk_i);
    check({tag, "_done_busy_after"}, {done_o, busy_o}, 2'b00);
    check({tag, "_err_sticky"}, {err_timeout_o, err_index_o}, {exp_to, exp_ei});
    repeat (3) @(negedge wb_clk_i);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_tx_bytes"}, tx_log.size() - tx0, 6);
    obs_frame = '0;
    if (tx_log.size() - tx0 == 6) begin
      for (int k = 0; k < 6; k++) obs_frame[(5-k)*8 +: 8] = tx_log[tx0 + k];
    end
    last_frame = obs_frame;
    check({tag, "_frame"}, obs_frame, exp_frame);
    check({tag, "_rx_reads"}, rd1_cnt - rd0, load_rsp ? n : 0);
    check({tag, "_protocol"}, prot_err, 0);
    if (exp_to) check({tag, "_timeout_window"}, (dt >= 20) && (dt <= 30), 1'b1);
  endtask

  initial begin
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic [1:0]  rrt;
    int          st0;
    bit          got;

    wb_rst_i   = 1'b1;
    start_i    = 1'b0;
    cmd_idx_i  = '0;
    cmd_arg_i  = '0;
    rsp_type_i = '0;
    repeat (3) @(negedge wb_clk_i);
    check("reset_outputs",
          {busy_o, done_o, err_timeout_o, err_index_o, bus.m_cyc_o, bus.m_stb_o, bus.m_we_o,
           bus.m_adr_o, bus.m_dat_o, bus.m_sel_o},
          {7'b0, 3'b0, 8'h00, 4'b0001});
    check("reset_resp", resp_o, 128'h0);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    run_txn("cmd0", 6'd0, 32'h0, 2'd0, 1'b1, 1'b0);
    check("cmd0_frame_const", last_frame, 48'h400000000095);

    rb[0] = 8'h08; rb[1] = 8'h00; rb[2] = 8'h00; rb[3] = 8'h01; rb[4] = 8'hAA; rb[5] = 8'h13;
    run_txn("cmd8", 6'd8, 32'h000001AA, 2'd1, 1'b1, 1'b0);
    check("cmd8_frame_const", last_frame, 48'h48000001AA87);
    check("cmd8_resp_const", resp_o[47:0], 48'h08000001AA13);

    rb[0] = 8'h3F;
    for (int k = 1; k < 6; k++) rb[k] = 8'($urandom_range(0, 255));
    run_txn("cmd17", 6'd17, 32'h0, 2'd1, 1'b1, 1'b0);
    check("cmd17_frame_const", last_frame, 48'h510000000055);
    check("cmd17_err_index_const", err_index_o, 1'b1);

    rb[0] = 8'h3F;
    for (int k = 1; k < 17; k++) rb[k] = 8'(k - 1);
    run_txn("cmd2", 6'd2, 32'h0, 2'd2, 1'b1, 1'b0);
    check("cmd2_resp_const", resp_o, 128'h000102030405060708090A0B0C0D0E0F);

    run_txn("timeout", 6'd55, 32'h12345678, 2'd1, 1'b0, 1'b0);

    st0 = st_cnt;
    tx_full_until = cyc_cnt + 50;
    rb[0] = 8'h08; rb[1] = 8'h00; rb[2] = 8'h00; rb[3] = 8'h01; rb[4] = 8'hAA; rb[5] = 8'h13;
    run_txn("txfull", 6'd8, 32'h000001AA, 2'd1, 1'b1, 1'b0);
    check("txfull_polled", (st_cnt - st0) >= 14, 1'b1);

    for (int k = 0; k < 17; k++) rb[k] = 8'($urandom_range(0, 255));
    run_txn("busy_start", 6'd41, 32'hDEADBEEF, 2'd3, 1'b1, 1'b1);

    @(negedge wb_clk_i);
    cmd_idx_i  = 6'd12;
    cmd_arg_i  = 32'hCAFEF00D;
    rsp_type_i = 2'd0;
    start_i    = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (bus.m_cyc_o && bus.m_we_o) got = 1;
      else @(negedge wb_clk_i);
    end
    check("rst_wr_reached", got, 1'b1);
    #2 wb_rst_i = 1'b1;
    #1 check("rst_async_drop", {bus.m_cyc_o, bus.m_stb_o, busy_o, done_o}, 4'b0000);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    run_txn("after_rst", 6'd0, 32'h0, 2'd0, 1'b1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      rrt  = 2'($urandom_range(0, 3));
      for (int k = 0; k < 17; k++) rb[k] = 8'($urandom_range(0, 255));
      if (rrt == 2'd1 && $urandom_range(0, 1) == 1) rb[0] = {2'b00, ridx};
      run_txn("rand", ridx, rarg, rrt, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Wishbone master that runs one complete SD command transaction through the 8-bit SD FIFO controller's slave port.
- Per transaction: builds the 6-byte command frame (start/transmission bits, index, argument, CRC7, end bit) and writes it into the TX command FIFO. Then polls status, drains the response bytes from the RX command FIFO with a timeout, and reports completion to a host-side requester.
- Sits between a host/CPU command register block and the FIFO controller.

Parameters:
- TIMEOUT, 16'd4095, wb_clk_i cycles allowed between consecutive received response bytes (and before the first byte).
- TW, 16, timeout counter width.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- start_i  in  1  request pulse; sampled only in IDLE
- cmd_idx_i  in  6  command index; sampled at accepted start
- cmd_arg_i  in  32  argument; sampled at accepted start
- rsp_type_i  in  2  0=none, 1=short (6 bytes), 2=long (17 bytes), 3=reserved (treated as none)
- busy_o  out  1  transaction in progress
- done_o  out  1  one-cycle completion pulse
- err_timeout_o  out  1  sticky until next accepted start
- err_index_o  out  1  short response byte0[5:0] != cmd_idx; sticky until next start
- resp_o  out  128  response shift register
- m_adr_o  out  3  slave address
- m_dat_o  out  8  write data
- m_dat_i  in  8  read data
- m_we_o  out  1  write enable
- m_sel_o  out  4  byte select; constant 4'b0001
- m_cyc_o  out  1  cycle
- m_stb_o  out  1  strobe
- m_ack_i  in  1  acknowledge

Behaviour:
- Reset: wb_rst_i is asynchronous, active-high; clock is wb_clk_i. On reset all outputs are 0 except m_sel_o; state=IDLE; resp_o=0.
- Slave map:
  - 0 = TX cmd FIFO (write)
  - 1 = RX cmd FIFO (read)
  - 4 = status: bit0 TX cmd full, bit1 RX cmd empty
- Bus rule:
  - Assert cyc+stb with stable adr/dat/we until m_ack_i is sampled high.
  - Deassert cyc/stb in the cycle after ack, and keep them low for at least 1 idle cycle before the next access (the slave requires the gap).
  - A single access takes ≥3 cycles.
- Frame bytes:
  - B0 = {2'b01, cmd_idx}
  - B1..B4 = arg[31:24] .. arg[7:0]
  - B5 = {crc7, 1'b1}
  - CRC7 polynomial x^7+x^3+1, initial value 0, computed over B0..B4, MSB first.
- FSM:
  - IDLE: on start_i, latch inputs, clear errors and resp_o, set busy_o, byte_cnt=0, go to TX_POLL.
  - TX_POLL: read status. If bit0=1, repeat the read (no timeout). Otherwise go to TX_WR.
  - TX_WR: write B[byte_cnt] to adr 0. On ack: if byte_cnt=5, go to RSP_CHK; else byte_cnt++ and go to TX_POLL.
  - RSP_CHK: if rsp_type is none/reserved, go to FINISH. Otherwise load rsp_len (6 or 17), reset the timer to TIMEOUT, byte_cnt=0, go to RX_POLL.
  - RX_POLL:
    - Read status each access; decrement the timer by 1 every wb_clk_i cycle while in RX_POLL.
    - If status bit1=0, go to RX_RD.
    - If the timer reaches 0 while bus is idle, set err_timeout_o and go to FINISH.
    - If the timer reaches 0 mid-access, complete that access first and then evaluate the timeout.
  - RX_RD:
    - Read adr 1. On ack: resp_o <= {resp_o[119:0], m_dat_i}.
    - On byte_cnt=0 with short type, compare m_dat_i[5:0] to the latched index; set err_index_o on mismatch.
    - Reload the timer to TIMEOUT.
    - If byte_cnt=rsp_len-1, go to FINISH; else byte_cnt++ and go to RX_POLL.
  - FINISH: pulse done_o for 1 cycle, clear busy_o, return to IDLE.
- Response packing:
  - Short: resp_o[47:0] holds the 6 bytes, byte0 in [47:40].
  - Long: the first byte shifts out; resp_o holds bytes 1..16.
- start_i while busy is ignored (not queued).
- Reset mid-transaction drops cyc/stb immediately. The FIFO controller shares the same reset, so no recovery is needed.
- Error outputs remain valid after done_o until the next accepted start.

Decomposition:
- Shared package (sd_defines include): slave addresses (tx/rx cmd, status), status bit positions, RSP_NONE/SHORT/LONG codes, frame start prefix 2'b01.
- Sub-module sd_crc7_byte: combinational 8-bit-per-step CRC7 update (crc_in[6:0], byte[7:0] -> crc_out[6:0]), iterated once per frame byte into a registered CRC.

Test Plan:
- CMD0, arg 0, rsp none -> adr0 writes 40 00 00 00 00 95. done_o 1 cycle after the last ack; no status read on adr1.
- CMD8, arg 0x000001AA, short; slave returns 08 00 00 01 AA 13 -> writes 48 00 00 01 AA 87; resp_o[47:0]=0x08000001AA13; err_index_o=0.
- CMD17, arg 0, short; slave returns 3F.. as byte0 -> writes 51 00 00 00 00 55; err_index_o=1; done_o still pulses.
- Long response (CMD2) with 17 bytes 3F,00..0F -> resp_o=0x000102..0F; exactly 17 adr1 reads.
- RX stays empty with TIMEOUT=20 -> err_timeout_o=1 and done_o within 20 + one access of the last write; TX full held 50 cycles -> polling continues, no error.
- start_i pulsed while busy -> ignored. Reset asserted mid-TX_WR -> m_cyc_o/m_stb_o=0 asynchronously, busy_o=0.
